// File: rtl/rx_frame_sync.sv
// Bit-serial frame synchroniser: hunts for a sync word (either polarity),
// then packs the following payload bits into bytes on a one-deep output.
module rx_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'hEB90,
  parameter int          PAYLOAD_BYTES = 16
) (
  input  logic        clk_1M024,
  input  logic        rst_n_1M024,
  input  logic        rx_bit,
  input  logic        rx_valid,
  input  logic [1:0]  sync_tol,
  output logic [7:0]  data_tdata,
  output logic        data_tvalid,
  input  logic        data_tready,
  output logic        data_tlast,
  output logic        data_tuser,
  output logic        locked,
  output logic        inverted,
  output logic [15:0] frame_cnt,
  output logic        overflow
);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  state_t      r_state;
  logic [15:0] r_sr;
  logic [4:0]  r_fill;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_byte_cnt;
  logic [7:0]  r_asm;
  logic        r_locked;
  logic        r_inverted;
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_tuser;
  logic        r_overflow;

  logic [15:0] w_sr_next;
  logic [4:0]  w_d0;
  logic [4:0]  w_d1;
  logic [4:0]  w_tol;
  logic        w_fill_ok;
  logic        w_hit0;
  logic        w_hit1;
  logic [7:0]  w_asm_next;
  logic        w_byte_done;
  logic        w_last_byte;
  logic        w_retire;
  logic        w_drop;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

  // Sync correlation and byte-completion decode for the current bit.
  always_comb begin
    w_sr_next   = {r_sr[14:0], rx_bit};
    w_d0        = popcnt16(w_sr_next ^ SYNC_WORD);
    w_d1        = popcnt16(w_sr_next ^ ~SYNC_WORD);
    w_tol       = {3'b000, sync_tol};
    // The bit being shifted now counts toward the 16-bit fill.
    w_fill_ok   = r_fill[4] || (r_fill == 5'd15);
    w_hit0      = w_fill_ok && (w_d0 <= w_tol);
    w_hit1      = w_fill_ok && (w_d1 <= w_tol);
    w_asm_next  = {r_asm[6:0], rx_bit ^ r_inverted};
    w_byte_done = (r_state == PAYLOAD) && rx_valid
                  && (r_bit_cnt == 3'd7);
    w_last_byte = (r_byte_cnt == LAST_IDX);
    w_retire    = r_tvalid && data_tready;
    w_drop      = w_byte_done && r_tvalid && !data_tready;
  end

  // Hunt/payload state machine with its shift, fill and byte counters.
  always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
    if (!rst_n_1M024) begin
      r_state     <= HUNT;
      r_sr        <= '0;
      r_fill      <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_asm       <= '0;
      r_locked    <= 1'b0;
      r_inverted  <= 1'b0;
      r_frame_cnt <= '0;
    end else if (rx_valid) begin
      unique case (r_state)
        HUNT: begin
          r_sr <= w_sr_next;
          if (!r_fill[4]) begin
            r_fill <= r_fill + 5'd1;
          end
          if (w_hit0 || w_hit1) begin
            r_state     <= PAYLOAD;
            r_locked    <= 1'b1;
            // True polarity wins when both polarities are in tolerance.
            r_inverted  <= !w_hit0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_asm       <= '0;
          end
        end
        PAYLOAD: begin
          r_asm     <= w_asm_next;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
            if (w_last_byte) begin
              r_state  <= HUNT;
              r_locked <= 1'b0;
              r_sr     <= '0;
              r_fill   <= '0;
            end
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  // One-deep output register; a byte arriving into a stalled slot is lost.
  always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
    if (!rst_n_1M024) begin
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_byte_done && !w_drop) begin
        r_tdata  <= w_asm_next;
        r_tvalid <= 1'b1;
        r_tuser  <= (r_byte_cnt == 8'd0);
        r_tlast  <= w_last_byte;
      end else if (w_retire) begin
        r_tvalid <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign data_tdata  = r_tdata;
  assign data_tvalid = r_tvalid;
  assign data_tlast  = r_tlast;
  assign data_tuser  = r_tuser;
  assign locked      = r_locked;
  assign inverted    = r_inverted;
  assign frame_cnt   = r_frame_cnt;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Bench for rx_frame_sync: directed frame table, hand corner cases,
// and randomized bit streams against a frame-level reference model.
module tb_rx_frame_sync;

  localparam logic [15:0] SW = 16'hEB90;
  localparam int PB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_bit = 1'b0;
  logic        rx_valid = 1'b0;
  logic [1:0]  sync_tol = 2'd0;
  logic [7:0]  data_tdata;
  logic        data_tvalid;
  logic        data_tready = 1'b1;
  logic        data_tlast;
  logic        data_tuser;
  logic        locked;
  logic        inverted;
  logic [15:0] frame_cnt;
  logic        overflow;

  int total = 0;
  int bad = 0;
  int beats;

  rx_frame_sync #(.SYNC_WORD(SW), .PAYLOAD_BYTES(PB)) dut (
    .clk_1M024   (clk),
    .rst_n_1M024 (rst_n),
    .rx_bit      (rx_bit),
    .rx_valid    (rx_valid),
    .sync_tol    (sync_tol),
    .data_tdata  (data_tdata),
    .data_tvalid (data_tvalid),
    .data_tready (data_tready),
    .data_tlast  (data_tlast),
    .data_tuser  (data_tuser),
    .locked      (locked),
    .inverted    (inverted),
    .frame_cnt   (frame_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: counts bits since hunt start and payload bits.
  bit          m_hunt;
  logic [15:0] m_hist;
  int          m_nbits;
  int          m_pbits;
  logic [7:0]  m_acc;
  bit          m_inv;
  logic [15:0] m_fc;
  bit          m_ovf;
  bit          m_tv;
  logic [7:0]  m_td;
  bit          m_tu;
  bit          m_tl;

  task automatic model_reset();
    m_hunt = 1; m_hist = '0; m_nbits = 0; m_pbits = 0;
    m_acc = '0; m_inv = 0; m_fc = '0; m_ovf = 0;
    m_tv = 0; m_td = '0; m_tu = 0; m_tl = 0;
  endtask

  task automatic model_step(input bit v, input bit b,
                            input int tol, input bit tr);
    bit ld;
    bit ret;
    int d0;
    int d1;
    int idx;
    ld = 0;
    ret = m_tv && tr;
    if (v) begin
      if (m_hunt) begin
        m_hist = {m_hist[14:0], b};
        m_nbits++;
        if (m_nbits >= 16) begin
          d0 = $countones(m_hist ^ SW);
          d1 = $countones(m_hist ^ ~SW);
          if (d0 <= tol || d1 <= tol) begin
            m_hunt = 0;
            m_inv = !(d0 <= tol);
            m_fc = m_fc + 16'd1;
            m_pbits = 0;
          end
        end
      end else begin
        m_acc = {m_acc[6:0], b ^ m_inv};
        m_pbits++;
        if (m_pbits % 8 == 0) begin
          idx = m_pbits / 8 - 1;
          if (m_tv && !tr) m_ovf = 1;
          else begin
            ld = 1; m_td = m_acc;
            m_tu = (idx == 0); m_tl = (idx == PB - 1);
          end
          if (idx == PB - 1) begin
            m_hunt = 1; m_nbits = 0; m_hist = '0;
          end
        end
      end
    end
    if (ld) m_tv = 1;
    else if (ret) m_tv = 0;
  endtask

  function automatic logic [31:0] dut_vec();
    return {2'b00, frame_cnt, overflow, inverted, locked, data_tvalid,
            data_tvalid ? data_tdata : 8'h00,
            data_tvalid & data_tuser, data_tvalid & data_tlast};
  endfunction

  function automatic logic [31:0] mdl_vec();
    return {2'b00, m_fc, m_ovf, m_inv, !m_hunt, m_tv,
            m_tv ? m_td : 8'h00, m_tv & m_tu, m_tv & m_tl};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit v, input bit b, input bit tr);
    rx_valid = v; rx_bit = b; data_tready = tr;
    @(posedge clk);
    model_step(v, b, int'(sync_tol), tr);
    #1;
    chk("model", dut_vec(), mdl_vec());
  endtask

  task automatic send_bit(input bit b, input int gap, input bit tr);
    for (int i = 1; i < gap; i++) cyc(0, 1'($urandom), tr);
    cyc(1, b, tr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0;
    model_reset();
    #1;
    chk("reset", dut_vec(), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Sync word then nbytes payload bytes 1..n (optionally inverted).
  task automatic run_frame(input logic [15:0] sync, input bit inv,
                           input int gap, input bit tr, input int nbytes,
                           input bit exp_on, input bit chkb);
    logic [7:0] by;
    beats = 0;
    for (int i = 15; i >= 0; i--) send_bit(sync[i], gap, tr);
    for (int k = 1; k <= nbytes; k++) begin
      by = inv ? ~8'(k) : 8'(k);
      for (int i = 7; i >= 0; i--) send_bit(by[i], gap, tr);
      if (data_tvalid) beats++;
      if (chkb) begin
        if (exp_on)
          chk("beat", {20'h0, data_tvalid, data_tdata,
                       data_tuser, data_tlast},
              {20'h0, 1'b1, 8'(k), k == 1, k == PB});
        else
          chk("nobeat", {31'h0, data_tvalid}, 32'h0);
      end
    end
  endtask

  typedef struct {
    logic [15:0] sync;
    logic [1:0]  tol;
    bit          inv;
    int          gap;
    int          exp_beats;
    bit          exp_inv;
    int          exp_fc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [15:0] s;
    tbl[0] = '{16'hEB90, 2'd0, 1'b0, 1, 16, 1'b0, 1};
    tbl[1] = '{16'h146F, 2'd0, 1'b1, 1, 16, 1'b1, 1};
    tbl[2] = '{16'hEB93, 2'd2, 1'b0, 1, 16, 1'b0, 1};
    tbl[3] = '{16'hEB93, 2'd1, 1'b0, 1, 0,  1'b0, 0};
    tbl[4] = '{16'hEB90, 2'd0, 1'b0, 4, 16, 1'b0, 1};

    for (int t = 0; t < 5; t++) begin
      sync_tol = tbl[t].tol;
      do_reset();
      run_frame(tbl[t].sync, tbl[t].inv, tbl[t].gap, 1'b1, PB,
                tbl[t].exp_beats > 0, 1'b1);
      chk("beats", 32'(beats), 32'(tbl[t].exp_beats));
      chk("frame_cnt", {16'h0, frame_cnt}, 32'(tbl[t].exp_fc));
      chk("inverted", {31'h0, inverted}, {31'h0, tbl[t].exp_inv});
      chk("unlocked", {31'h0, locked}, 32'h0);
    end

    // Backpressure for a whole frame: only the first byte survives.
    sync_tol = 2'd0;
    do_reset();
    run_frame(SW, 1'b0, 1, 1'b0, PB, 1'b0, 1'b0);
    chk("bp_hold", {20'h0, data_tvalid, data_tdata, data_tuser,
                    data_tlast}, {20'h0, 1'b1, 8'h01, 1'b1, 1'b0});
    chk("bp_ovf", {30'h0, overflow, locked}, {30'h0, 1'b1, 1'b0});
    cyc(0, 1'b0, 1'b1);
    chk("bp_retire", {31'h0, data_tvalid}, 32'h0);
    chk("bp_sticky", {31'h0, overflow}, 32'h1);

    // Reset in the middle of a frame with a byte on the output.
    do_reset();
    run_frame(SW, 1'b0, 1, 1'b1, 5, 1'b1, 1'b1);
    chk("mid_valid", {31'h0, data_tvalid}, 32'h1);
    do_reset();
    run_frame(SW, 1'b0, 1, 1'b1, PB, 1'b1, 1'b1);
    chk("mid_beats", 32'(beats), 32'(PB));
    chk("mid_fc", {16'h0, frame_cnt}, 32'h1);

    // Random streams with embedded, damaged and inverted sync words.
    do_reset();
    for (int seg = 0; seg < 70; seg++) begin
      sync_tol = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
          send_bit(1'($urandom), $urandom_range(1, 3),
                   $urandom_range(0, 2) != 0);
        end
      end else begin
        s = $urandom_range(0, 1) ? ~SW : SW;
        for (int e = 0; e < int'($urandom_range(0, 3)); e++) begin
          s[$urandom_range(0, 15)] ^= 1'b1;
        end
        for (int i = 15; i >= 0; i--) begin
          send_bit(s[i], $urandom_range(1, 3), $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 8 * PB; i++) begin
          send_bit(1'($urandom), $urandom_range(1, 3),
                   $urandom_range(0, 2) != 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_sync.md
RX_FRAME_SYNC -- requirements
Module: rx_frame_sync

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hEB90: frame sync pattern, transmitted MSB first.
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 16: payload bytes per frame, legal range 1..255.
REQ-003 SHALL have ports; one clock; reset is asynchronous and active-low:
- clk_1M024  in  1  symbol-rate clock.
- rst_n_1M024  in  1  asynchronous active-low reset.
- rx_bit  in  1  hard-decision bit from Rx (Rx_1bit).
- rx_valid  in  1  qualifies rx_bit, one bit per high cycle.
- sync_tol  in  2  max Hamming distance accepted for sync match.
- data_tdata  out  8  payload byte.
- data_tvalid  out  1  byte valid.
- data_tready  in  1  downstream accept.
- data_tlast  out  1  last payload byte of frame.
- data_tuser  out  1  first payload byte of frame.
- locked  out  1  high while in PAYLOAD state.
- inverted  out  1  current frame matched ~SYNC_WORD (BPSK phase ambiguity).
- frame_cnt  out  16  frames detected, wraps at 16'hFFFF -> 0.
- overflow  out  1  sticky, byte dropped due to backpressure.

Function
REQ-004 SHALL advance all bit-level state only on cycles with rx_valid=1; with rx_valid=0, shift register, counters and FSM SHALL hold.
REQ-005 SHALL keep a 16-bit shift register sr; on valid bit, sr_next = {sr[14:0], rx_bit}.
REQ-006 SHALL run FSM with states HUNT and PAYLOAD; reset state HUNT.
REQ-007 In HUNT, SHALL compute d0 = popcount(sr_next ^ SYNC_WORD) and d1 = popcount(sr_next ^ ~SYNC_WORD) on each valid bit; only after at least 16 bits have been shifted since entering HUNT.
REQ-008 If d0 <= sync_tol: go to PAYLOAD, inverted<=0; else if d1 <= sync_tol: go to PAYLOAD, inverted<=1; d0 checked first on tie.
REQ-009 On sync detect, SHALL increment frame_cnt (mod 2^16) and clear bit counter (3-bit) and byte counter (8-bit).
REQ-010 In PAYLOAD, each valid bit SHALL be XORed with inverted and shifted MSB first into an 8-bit assembly register.
REQ-011 On the valid bit completing a byte, the byte SHALL be presented on data_tdata with data_tvalid=1 on the next clock edge (latency 1 cycle from the 8th bit's rx_valid cycle).
REQ-012 data_tuser SHALL be 1 with byte index 0; data_tlast SHALL be 1 with byte index PAYLOAD_BYTES-1; both 1 when PAYLOAD_BYTES=1.
REQ-013 data_tdata/tlast/tuser SHALL be stable while data_tvalid=1 and data_tready=0; byte retires on tvalid & tready.
REQ-014 If a byte completes while data_tvalid=1 and data_tready=0 in the same cycle, the new byte SHALL be dropped, overflow set to 1 (sticky until reset), and byte counter still advanced.
REQ-015 If a byte completes in the same cycle the held byte retires (tvalid & tready), the new byte SHALL be loaded, no overflow.
REQ-016 After the byte with index PAYLOAD_BYTES-1 completes, FSM SHALL return to HUNT, sr cleared to 0, and the 16-bit fill counter reset (REQ-007 gating).
REQ-017 locked SHALL equal (state==PAYLOAD); inverted SHALL hold its value until next sync detect.
REQ-018 Output queue depth SHALL be one register; no other buffering.

Reset
REQ-019 On rst_n_1M024=0, asynchronously: state HUNT, sr=0, fill/bit/byte counters=0, data_tvalid=0, data_tdata=0, data_tlast=0, data_tuser=0, locked=0, inverted=0, frame_cnt=0, overflow=0.
REQ-020 Reset asserted mid-frame SHALL discard the partial byte and any held output byte; after release, module SHALL require a fresh full sync word.

Verification
REQ-021 Clean frame: rx_valid=1 every cycle, bits 16'hEB90 then bytes 8'h01..8'h10, tready=1 -> 16 beats 01..10, tuser on 01, tlast on 10, frame_cnt=1, inverted=0.
REQ-022 Inverted frame: bits 16'h146F then bitwise-inverted bytes 8'hFE..8'hEF -> output 01..10, inverted=1, frame_cnt=1.
REQ-023 Tolerance: sync with 2 bit errors (16'hEB93), sync_tol=2 -> locks; sync_tol=1 -> stays HUNT, no output, frame_cnt=0.
REQ-024 Backpressure: tready=0 throughout one frame -> only byte 01 presented and held, overflow=1, FSM returns to HUNT after 16 bytes; tready=1 then retires 01.
REQ-025 Gapped valid: rx_valid high 1 cycle in 4 for a clean frame -> identical byte sequence, each tvalid one cycle after 8th bit's valid.
REQ-026 Reset mid-frame: assert rst_n_1M024=0 after 5 payload bytes -> all outputs 0 immediately; next clean frame yields full 16 bytes, frame_cnt=1.
